ysyx_22040237_ifu: RTL and testbench

Instruction fetch unit that produces the pc/inst pair consumed by the decode stage, and accepts next-pc redirects (jal/jalr targets) back from execute. It holds the architectural PC and runs a request/response handshake to instruction memory. It presents one fetched instruction at a time to decode with a valid/ready handshake. Fetch faults are detected and reported as sticky flags for the simulation environment.

---
 rtl/ysyx_22040237_ifu_pkg.sv | 23 ++
 rtl/ysyx_22040237_ifu_wdt.sv | 26 ++
 rtl/ysyx_22040237_ifu.sv | 130 +++++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, fault causes, widths.
package ysyx_22040237_ifu_pkg;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef logic [1:0] state_t;

  localparam state_t S_REQ  = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_HOLD = 2'd2;
  localparam state_t S_IDLE = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS      = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040237_ifu_wdt.sv
// 8-bit clearable watchdog; o_tc flags that the count has reached TIMEOUT.
module ysyx_22040237_ifu_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 8'(TIMEOUT))) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = (r_cnt == 8'(TIMEOUT));

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time from memory and
// presents it to decode; bus errors, misaligned jump targets and timeouts stop fetching.
module ysyx_22040237_ifu
  import ysyx_22040237_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_mem_req_valid,
  output logic [31:0]       o_mem_req_addr,
  input  logic              i_mem_req_ready,
  input  logic              i_mem_resp_valid,
  input  logic [INST_W-1:0] i_mem_resp_data,
  input  logic              i_mem_resp_err,
  output logic [31:0]       o_ifu_pc,
  output logic [INST_W-1:0] o_ifu_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  input  logic              i_halt,
  output logic              o_fetch_fault,
  output logic [1:0]        o_fault_cause,
  output logic [CNT_W-1:0]  o_inst_cnt
);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic [31:0]       r_ifu_pc;
  logic [INST_W-1:0] r_ifu_inst;
  logic              r_fault, w_fault_nxt;
  logic [1:0]        r_cause, w_cause_nxt;
  logic [CNT_W-1:0]  r_inst_cnt;
  logic              w_tc, w_resp_ok, w_consume;
  logic [31:0]       w_jump_pc;

  ysyx_22040237_ifu_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != S_WAIT),
    .i_en  (r_state == S_WAIT),
    .o_tc  (w_tc)
  );

  assign w_resp_ok = (r_state == S_WAIT) && i_mem_resp_valid && !i_mem_resp_err;
  assign w_consume = (r_state == S_HOLD) && i_inst_ready;
  assign w_jump_pc = i_redirect_valid ? i_redirect_pc : r_pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_cause_nxt = r_cause;
    case (r_state)
      S_REQ: begin
        if (i_mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving on the terminal-count cycle still wins over the timeout.
        if (i_mem_resp_valid) begin
          if (i_mem_resp_err) begin
            w_state_nxt = S_IDLE;
            w_fault_nxt = 1'b1;
            w_cause_nxt = CAUSE_BUS;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else if (w_tc) begin
          w_state_nxt = S_IDLE;
          w_fault_nxt = 1'b1;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_HOLD: begin
        if (i_inst_ready) begin
          if (i_halt) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = w_jump_pc;
          end else if (i_redirect_valid && is_misaligned(i_redirect_pc)) begin
            w_state_nxt = S_IDLE;
            w_fault_nxt = 1'b1;
            w_cause_nxt = CAUSE_MISALIGN;
          end else begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = w_jump_pc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_ifu_pc   <= '0;
      r_ifu_inst <= '0;
      r_fault    <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_inst_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
      r_cause <= w_cause_nxt;
      if (w_resp_ok) begin
        r_ifu_pc   <= r_pc;
        r_ifu_inst <= i_mem_resp_data;
      end
      if (w_consume) r_inst_cnt <= r_inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Request is held low for the whole reset pulse even though the reset state is S_REQ.
  assign o_mem_req_valid = (r_state == S_REQ) && !rst;
  assign o_mem_req_addr  = r_pc;
  assign o_inst_valid    = (r_state == S_HOLD);
  assign o_ifu_pc        = r_ifu_pc;
  assign o_ifu_inst      = r_ifu_inst;
  assign o_fetch_fault   = r_fault;
  assign o_fault_cause   = r_cause;
  assign o_inst_cnt      = r_inst_cnt;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Randomised bench for the fetch unit: the bench plays memory and decode, and a
// transaction-level model tracks the expected pc, count and fault state.
module tb_ysyx_22040237_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_req_addr, mem_resp_data, ifu_pc, ifu_inst, redirect_pc;
  logic        inst_valid, inst_ready, redirect_valid, halt, fetch_fault;
  logic [1:0]  fault_cause;
  logic [63:0] inst_cnt;

  always #5 clk = ~clk;

  ysyx_22040237_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .o_mem_req_valid  (mem_req_valid),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_req_ready  (mem_req_ready),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .i_mem_resp_err   (mem_resp_err),
    .o_ifu_pc         (ifu_pc),
    .o_ifu_inst       (ifu_inst),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt           (halt),
    .o_fetch_fault    (fetch_fault),
    .o_fault_cause    (fault_cause),
    .o_inst_cnt       (inst_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural pc, consumed count, sticky fault, fetching stopped.
  logic [31:0] m_pc;
  logic [63:0] m_cnt;
  logic        m_fault;
  logic [1:0]  m_cause;
  bit          m_dead;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
  endtask

  // Inputs that must be ignored outside the consume cycle.
  task automatic noise();
    redirect_valid = 1'($urandom);
    redirect_pc    = $urandom;
    halt           = 1'($urandom);
    inst_ready     = 1'($urandom);
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_cnt   = '0;
    m_fault = 1'b0;
    m_cause = 2'b00;
    m_dead  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'(1'b0));
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'(1'b0));
    chk({tag, "_inst"}, 64'(ifu_inst), 64'(0));
    chk({tag, "_cnt"}, inst_cnt, 64'(0));
    chk({tag, "_fault"}, 64'(fetch_fault), 64'(1'b0));
    chk({tag, "_cause"}, 64'(fault_cause), 64'(0));
  endtask

  task automatic apply_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #1 check_reset_values("rst");
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic fetch_one(input int req_dly, input int resp_dly, input int hold_dly,
                           input logic [31:0] data, input bit err, input bit to,
                           input bit redir, input logic [31:0] rpc, input bit hlt);
    logic [31:0] nxt;
    chk("req_valid", 64'(mem_req_valid), 64'(1'b1));
    chk("req_addr", 64'(mem_req_addr), 64'(m_pc));
    for (int i = 0; i < req_dly; i++) begin
      noise();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'($urandom);
      tick();
      chk("req_stall_valid", 64'(mem_req_valid), 64'(1'b1));
      chk("req_stall_addr", 64'(mem_req_addr), 64'(m_pc));
    end
    noise();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    chk("wait_req_low", 64'(mem_req_valid), 64'(1'b0));
    if (to) begin
      for (int i = 0; i < 255; i++) begin
        noise();
        tick();
      end
      chk("to_pending", 64'(fetch_fault), 64'(1'b0));
      noise();
      tick();
      idle_inputs();
      m_fault = 1'b1;
      m_cause = 2'b11;
      m_dead  = 1'b1;
      chk("to_fault", 64'(fetch_fault), 64'(m_fault));
      chk("to_cause", 64'(fault_cause), 64'(m_cause));
      return;
    end
    for (int i = 0; i < resp_dly; i++) begin
      noise();
      tick();
      chk("wait_no_valid", 64'(inst_valid), 64'(1'b0));
    end
    noise();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    tick();
    idle_inputs();
    if (err) begin
      m_fault = 1'b1;
      m_cause = 2'b01;
      m_dead  = 1'b1;
      chk("err_fault", 64'(fetch_fault), 64'(m_fault));
      chk("err_cause", 64'(fault_cause), 64'(m_cause));
      chk("err_no_valid", 64'(inst_valid), 64'(1'b0));
      return;
    end
    chk("hold_valid", 64'(inst_valid), 64'(1'b1));
    chk("hold_pc", 64'(ifu_pc), 64'(m_pc));
    chk("hold_inst", 64'(ifu_inst), 64'(data));
    for (int i = 0; i < hold_dly; i++) begin
      noise();
      inst_ready     = 1'b0;
      mem_resp_valid = 1'($urandom);
      mem_resp_data  = $urandom;
      tick();
      chk("bp_valid", 64'(inst_valid), 64'(1'b1));
      chk("bp_pc", 64'(ifu_pc), 64'(m_pc));
      chk("bp_inst", 64'(ifu_inst), 64'(data));
      chk("bp_no_req", 64'(mem_req_valid), 64'(1'b0));
      chk("bp_cnt", inst_cnt, m_cnt);
    end
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    mem_resp_valid = 1'($urandom);
    tick();
    idle_inputs();
    m_cnt = m_cnt + 64'd1;
    nxt = redir ? rpc : m_pc + 32'd4;
    if (hlt) begin
      m_pc   = nxt;
      m_dead = 1'b1;
    end else if (redir && (rpc[1:0] != 2'b00)) begin
      m_fault = 1'b1;
      m_cause = 2'b10;
      m_dead  = 1'b1;
    end else begin
      m_pc = nxt;
    end
    chk("cnt", inst_cnt, m_cnt);
    chk("consumed", 64'(inst_valid), 64'(1'b0));
    chk("next_req", 64'(mem_req_valid), 64'(!m_dead));
    chk("next_pc", 64'(mem_req_addr), 64'(m_pc));
    chk("fault", 64'(fetch_fault), 64'(m_fault));
    chk("cause", 64'(fault_cause), 64'(m_cause));
  endtask

  task automatic dead_check(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = 1'($urandom);
      mem_resp_err   = 1'($urandom);
      tick();
      chk("dead_req", 64'(mem_req_valid), 64'(1'b0));
      chk("dead_valid", 64'(inst_valid), 64'(1'b0));
      chk("dead_fault", 64'(fetch_fault), 64'(m_fault));
      chk("dead_cause", 64'(fault_cause), 64'(m_cause));
      chk("dead_cnt", inst_cnt, m_cnt);
    end
    idle_inputs();
  endtask

  task automatic reset_mid_wait();
    chk("rmw_req", 64'(mem_req_valid), 64'(1'b1));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1 check_reset_values("rmw");
    @(negedge clk);
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    model_reset();
    #1;
    chk("late_req", 64'(mem_req_valid), 64'(1'b1));
    chk("late_addr", 64'(mem_req_addr), 64'(RST_PC));
    tick();
    mem_resp_valid = 1'b0;
    chk("late_ignored", 64'(inst_valid), 64'(1'b0));
    chk("late_req2", 64'(mem_req_valid), 64'(1'b1));
    chk("late_addr2", 64'(mem_req_addr), 64'(RST_PC));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    model_reset();
    apply_reset();

    fetch_one(0, 0, 0, 32'h0000_0413, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_one(0, 1, 0, $urandom, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0);
    fetch_one(0, 2, 5, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_one(4, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 24; n++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                1'b0, 1'b0, ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, 1'b0);
    end
    fetch_one(1, 1, 0, $urandom, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    dead_check(4);

    apply_reset();
    fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 32'h8000_0102, 1'b0);
    dead_check(3);

    apply_reset();
    fetch_one(0, 0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    dead_check(3);

    apply_reset();
    fetch_one(0, 0, 0, $urandom | 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_one(1, 0, 1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset_mid_wait();
    fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_one(0, 1, 2, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    dead_check(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
